// File: rtl/pc_unit.sv
// Program counter with IDLE/RUN/DONE sequencing and a writable branch-target table.
// Latency: pc_o registered (branch target one cycle after the branch); taken_o combinational.
// Backpressure: stall_i freezes pc_o and masks halt/branch; optional RUN-cycle counter under PC_UNIT_CYCLE_CNT_EN.
module pc_unit #(
    parameter int                  PC_W       = 10,
    parameter int                  LUT_DEPTH  = 16,
    parameter logic [PC_W-1:0]     START_ADDR = '0,
    localparam int                 IDX_W      = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             branch_i,
    input  logic             one_i,
    input  logic [IDX_W-1:0] lut_idx_i,
    input  logic             lut_we_i,
    input  logic [IDX_W-1:0] lut_waddr_i,
    input  logic [PC_W-1:0]  lut_wdata_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             taken_o,
    output logic             running_o,
    output logic             done_o,
    output logic [15:0]      cycle_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] r_lut [LUT_DEPTH];
    logic [PC_W-1:0] w_target;
    logic            w_active;
    logic            w_taken;

    assign w_active = (r_state == ST_RUN) && !stall_i;
    assign w_taken  = w_active && !halt_i && branch_i && one_i;
    // Out-of-range indices (non power-of-two depth) read as zero rather than X.
    assign w_target = (int'(lut_idx_i) < LUT_DEPTH) ? r_lut[lut_idx_i] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = START_ADDR;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (halt_i)
                        w_state_nxt = ST_DONE;
                    else if (w_taken)
                        w_pc_nxt = w_target;
                    else
                        w_pc_nxt = r_pc + 1'b1;
                end
            end
            ST_DONE: begin
                if (!start_i)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= START_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Reads above see the pre-write entry, so a same-cycle write lands after the branch uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++)
                r_lut[i] <= '0;
        end else if (lut_we_i && (int'(lut_waddr_i) < LUT_DEPTH)) begin
            r_lut[lut_waddr_i] <= lut_wdata_i;
        end
    end

`ifdef PC_UNIT_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cycle_cnt <= '0;
        else if ((r_state == ST_IDLE) && start_i)
            r_cycle_cnt <= '0;
        else if ((r_state == ST_RUN) && (r_cycle_cnt != 16'hFFFF))
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end

    assign cycle_cnt_o = r_cycle_cnt;
`else
    assign cycle_cnt_o = '0;
`endif

    assign pc_o      = r_pc;
    assign taken_o   = w_taken;
    assign running_o = (r_state == ST_RUN);
    assign done_o    = (r_state == ST_DONE);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, branches, table write hazard, wrap, stall, async reset.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        stall_i;
    logic        halt_i;
    logic        branch_i;
    logic        one_i;
    logic [3:0]  lut_idx_i;
    logic        lut_we_i;
    logic [3:0]  lut_waddr_i;
    logic [9:0]  lut_wdata_i;
    logic [9:0]  pc_o;
    logic        taken_o;
    logic        running_o;
    logic        done_o;
    logic [15:0] cycle_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .halt_i      (halt_i),
        .branch_i    (branch_i),
        .one_i       (one_i),
        .lut_idx_i   (lut_idx_i),
        .lut_we_i    (lut_we_i),
        .lut_waddr_i (lut_waddr_i),
        .lut_wdata_i (lut_wdata_i),
        .pc_o        (pc_o),
        .taken_o     (taken_o),
        .running_o   (running_o),
        .done_o      (done_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] wr_addr [5];
    logic [9:0] wr_data [5];

    initial begin
        wr_addr[0] = 4'd3; wr_data[0] = 10'h120;
        wr_addr[1] = 4'd2; wr_data[1] = 10'd20;
        wr_addr[2] = 4'd4; wr_data[2] = 10'd7;
        wr_addr[3] = 4'd5; wr_data[3] = 10'd12;
        wr_addr[4] = 4'd6; wr_data[4] = 10'h3FF;

        rst_n = 1'b0; start_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0;
        branch_i = 1'b0; one_i = 1'b0; lut_idx_i = '0;
        lut_we_i = 1'b0; lut_waddr_i = '0; lut_wdata_i = '0;
        #12;
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_running", 32'(running_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            lut_we_i = 1'b1; lut_waddr_i = wr_addr[i]; lut_wdata_i = wr_data[i];
            tick();
        end
        lut_we_i = 1'b0;
        chk("idle_pc", 32'(pc_o), 32'd0);
        chk("idle_running", 32'(running_o), 32'd0);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_pc", 32'(pc_o), 32'd0);
        chk("start_running", 32'(running_o), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", 32'(pc_o), 32'(i));
        end
        chk("seq_running", 32'(running_o), 32'd1);
        tick(); tick();
        chk("pc7", 32'(pc_o), 32'd7);

        branch_i = 1'b1; one_i = 1'b1; lut_idx_i = 4'd3;
        #1 chk("br_taken", 32'(taken_o), 32'd1);
        tick();
        chk("br_target", 32'(pc_o), 32'h120);
        lut_idx_i = 4'd4;
        tick();
        chk("br_back7", 32'(pc_o), 32'd7);
        one_i = 1'b0; lut_idx_i = 4'd3;
        #1 chk("nt_taken", 32'(taken_o), 32'd0);
        tick();
        chk("nt_pc", 32'(pc_o), 32'd8);

        one_i = 1'b1; lut_idx_i = 4'd2;
        lut_we_i = 1'b1; lut_waddr_i = 4'd2; lut_wdata_i = 10'd50;
        #1 chk("wr_br_taken", 32'(taken_o), 32'd1);
        tick();
        lut_we_i = 1'b0;
        chk("wr_br_old", 32'(pc_o), 32'd20);
        tick();
        chk("wr_br_new", 32'(pc_o), 32'd50);
        lut_idx_i = 4'd5;
        tick();
        chk("pc12", 32'(pc_o), 32'd12);

        halt_i = 1'b1;
        #1 chk("halt_taken", 32'(taken_o), 32'd0);
        tick();
        halt_i = 1'b0; branch_i = 1'b0; one_i = 1'b0;
        chk("halt_done", 32'(done_o), 32'd1);
        chk("halt_running", 32'(running_o), 32'd0);
        chk("halt_pc", 32'(pc_o), 32'd12);
        start_i = 1'b1;
        tick();
        chk("done_hold", 32'(done_o), 32'd1);
        chk("done_pc", 32'(pc_o), 32'd12);
        start_i = 1'b0;
        tick();
        chk("to_idle_done", 32'(done_o), 32'd0);
        chk("to_idle_running", 32'(running_o), 32'd0);
        chk("to_idle_pc", 32'(pc_o), 32'd12);
        branch_i = 1'b1; one_i = 1'b1;
        #1 chk("idle_taken", 32'(taken_o), 32'd0);
        branch_i = 1'b0; one_i = 1'b0;

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_pc", 32'(pc_o), 32'd0);
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("run_start_ign", 32'(pc_o), 32'd2);
        chk("run_start_run", 32'(running_o), 32'd1);
        branch_i = 1'b1; one_i = 1'b1; lut_idx_i = 4'd6;
        tick();
        chk("pc_max", 32'(pc_o), 32'h3FF);
        branch_i = 1'b0; one_i = 1'b0;
        tick();
        chk("pc_wrap", 32'(pc_o), 32'd0);

        stall_i = 1'b1; halt_i = 1'b1; branch_i = 1'b1; one_i = 1'b1;
        #1 chk("stall_taken", 32'(taken_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(pc_o), 32'd0);
            chk("stall_running", 32'(running_o), 32'd1);
        end
`ifdef PC_UNIT_CYCLE_CNT_EN
        chk("stall_cnt", 32'(cycle_cnt_o), 32'd7);
`else
        chk("stall_cnt", 32'(cycle_cnt_o), 32'd0);
`endif
        stall_i = 1'b0; halt_i = 1'b0; branch_i = 1'b0; one_i = 1'b0;
        for (int i = 0; i < 9; i++)
            tick();
        chk("pc9", 32'(pc_o), 32'd9);

        #3 rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc_o), 32'd0);
        chk("arst_running", 32'(running_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_cnt", 32'(cycle_cnt_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_running", 32'(running_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        branch_i = 1'b1; one_i = 1'b1; lut_idx_i = 4'd3;
        tick();
        chk("lut_cleared", 32'(pc_o), 32'd0);
        branch_i = 1'b0; one_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter PC_W, default 10, program-counter width in bits.
REQ-002 SHALL provide parameter LUT_DEPTH, default 16, number of branch-target table entries.
REQ-003 SHALL provide parameter START_ADDR, default 0, PC value loaded on reset and on start.
REQ-004 SHALL provide ports as follows; one clock; reset is asynchronous and active-low:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  begin program execution
- stall_i  input  1  hold PC this cycle
- halt_i  input  1  current instruction is halt
- branch_i  input  1  current instruction is conditional branch
- one_i  input  1  ALU branch flag (1 = condition true)
- lut_idx_i  input  log2(LUT_DEPTH)  branch-target table index for current branch
- lut_we_i  input  1  branch-target table write enable
- lut_waddr_i  input  log2(LUT_DEPTH)  table write address
- lut_wdata_i  input  PC_W  table write data
- pc_o  output  PC_W  registered program counter
- taken_o  output  1  branch taken this cycle (combinational)
- running_o  output  1  state is RUN
- done_o  output  1  state is DONE
- cycle_cnt_o  output  16  RUN-cycle count (see Configuration)

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 IDLE: start_i=1 -> RUN next cycle, pc_o=START_ADDR; otherwise stay, pc_o held.
REQ-007 RUN, stall_i=1: pc_o held; halt_i, branch_i ignored; taken_o=0.
REQ-008 RUN, stall_i=0, halt_i=1: -> DONE, pc_o held; halt has priority over branch.
REQ-009 RUN, stall_i=0, halt_i=0, branch_i=1, one_i=1: pc_o <= lut[lut_idx_i] next edge; taken_o=1 this cycle.
REQ-010 RUN, all other cases: pc_o <= pc_o+1 modulo 2^PC_W (max wraps to 0).
REQ-011 taken_o SHALL equal RUN & !stall_i & !halt_i & branch_i & one_i; 0 in IDLE/DONE.
REQ-012 start_i in RUN SHALL be ignored.
REQ-013 DONE: done_o=1, pc_o held; start_i=0 -> IDLE next cycle; start_i=1 -> stay DONE.
REQ-014 Table write SHALL occur at the clock edge when lut_we_i=1, in any state.
REQ-015 Same-cycle write and branch to same index SHALL use the pre-write entry; new value visible next cycle.
REQ-016 Branch latency: taken target appears on pc_o exactly one cycle after the branch cycle.

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, pc_o=START_ADDR, all table entries 0, cycle_cnt_o=0, without waiting for clk.
REQ-018 Reset asserted mid-RUN SHALL abort execution; first post-reset cycle is IDLE with done_o=0, running_o=0.

Configuration
REQ-019 Macro PC_UNIT_CYCLE_CNT_EN defined: cycle_cnt_o increments once per RUN cycle (stalled cycles included), saturates at 16'hFFFF, clears on transition IDLE->RUN, holds in IDLE/DONE.
REQ-020 Macro undefined: cycle_cnt_o SHALL be constant 0 and no counter register instantiated.

Verification
REQ-021 Reset, start_i pulse, no branches, 5 cycles -> pc_o 0,1,2,3,4,5; running_o=1.
REQ-022 Write lut[3]=10'h120; in RUN at pc=7, branch_i=1, one_i=1, lut_idx_i=3 -> taken_o=1, next pc_o=10'h120; same with one_i=0 -> pc_o=8.
REQ-023 halt_i=1 and branch_i=1, one_i=1 same cycle at pc=12 -> DONE, pc_o=12, done_o=1, taken_o=0; start_i=0 -> IDLE.
REQ-024 pc_o=10'h3FF, no branch -> pc_o=0; stall_i=1 for 3 cycles -> pc_o unchanged, cycle_cnt_o +3 with macro defined.
REQ-025 lut_we_i writing lut[2]=50 while branching via idx 2 (old 20) -> next pc_o=20; next branch via idx 2 -> 50.
REQ-026 rst_n low between edges mid-RUN at pc=9 -> pc_o=0 and running_o=0 immediately; macro undefined -> cycle_cnt_o=0 throughout.
